// File: rtl/add_sub_pipe_if.sv
// Handshake bundle for add_sub_pipe: operand channel in, result channel out.
interface add_sub_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, sub, sat, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero, negative
    );

    // The arithmetic pipeline itself.
    modport slave (
        input  in_valid, a, b, sub, sat, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero, negative
    );
endinterface

// File: rtl/add_sub_pipe.sv
// Carry-chained add/subtract pipeline: one CHUNK-bit slice per stage, with
// saturation and flags resolved in the last stage so every output is a register.
module add_sub_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    add_sub_pipe_if.slave bus
);
    localparam int unsigned NSTG = WIDTH / CHUNK;
    localparam int unsigned NMID = (NSTG > 1) ? NSTG - 1 : 1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic adv;
    logic vld [NSTG];

    // Registers between stage k and k+1 (only stages 0..NSTG-2 write them).
    logic [WIDTH-1:0] mid_a   [NMID];
    logic [WIDTH-1:0] mid_b   [NMID];
    logic [WIDTH-1:0] mid_acc [NMID];
    logic             mid_c   [NMID];
    logic             mid_s   [NMID];

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    // Whole pipe moves together whenever the output slot is free or drained.
    assign adv          = !vld[NSTG-1] || bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = vld[NSTG-1];
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        logic             v_in;
        logic             ci;
        logic             cs;
        logic [CHUNK-1:0] ca;
        logic [CHUNK-1:0] cb;
        logic [CHUNK:0]   csum;

        // Stage source: the operand channel for stage 0, the previous stage otherwise.
        if (k == 0) begin : g_src_head
            assign v_in = bus.in_valid;
            assign ci   = bus.sub;
            assign cs   = bus.sat;
            assign ca   = bus.a[CHUNK-1:0];
            assign cb   = bus.b[CHUNK-1:0] ^ {CHUNK{bus.sub}};
        end else begin : g_src_body
            assign v_in = vld[k-1];
            assign ci   = mid_c[k-1];
            assign cs   = mid_s[k-1];
            assign ca   = mid_a[k-1][k*CHUNK +: CHUNK];
            assign cb   = mid_b[k-1][k*CHUNK +: CHUNK];
        end

        assign csum = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, ci};

        if (k < NSTG - 1) begin : g_mid
            logic [WIDTH-1:0] fa;
            logic [WIDTH-1:0] fb;
            logic [WIDTH-1:0] acc_n;

            if (k == 0) begin : g_op_head
                assign fa    = bus.a;
                assign fb    = bus.b ^ {WIDTH{bus.sub}};
                assign acc_n = WIDTH'(csum[CHUNK-1:0]);
            end else begin : g_op_body
                assign fa = mid_a[k-1];
                assign fb = mid_b[k-1];
                always_comb begin
                    acc_n                     = mid_acc[k-1];
                    acc_n[k*CHUNK +: CHUNK]   = csum[CHUNK-1:0];
                end
            end

            // Data registers only load for real transactions; bubbles just clear valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld[k]     <= 1'b0;
                    mid_a[k]   <= '0;
                    mid_b[k]   <= '0;
                    mid_acc[k] <= '0;
                    mid_c[k]   <= 1'b0;
                    mid_s[k]   <= 1'b0;
                end else if (adv) begin
                    vld[k] <= v_in;
                    if (v_in) begin
                        mid_a[k]   <= fa;
                        mid_b[k]   <= fb;
                        mid_acc[k] <= acc_n;
                        mid_c[k]   <= csum[CHUNK];
                        mid_s[k]   <= cs;
                    end
                end
            end
        end else begin : g_tail
            logic [WIDTH-1:0] raw;
            logic [WIDTH-1:0] fin;
            logic             ovf;

            if (k == 0) begin : g_raw_single
                assign raw = WIDTH'(csum[CHUNK-1:0]);
            end else begin : g_raw_multi
                assign raw = {csum[CHUNK-1:0], mid_acc[k-1][k*CHUNK-1:0]};
            end

            // Top slice carries both operand sign bits (b already inverted for sub).
            assign ovf = (ca[CHUNK-1] == cb[CHUNK-1]) && (raw[WIDTH-1] != ca[CHUNK-1]);
            assign fin = (cs && ovf) ? (ca[CHUNK-1] ? SMIN : SMAX) : raw;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld[k]   <= 1'b0;
                    result_q <= '0;
                    carry_q  <= 1'b0;
                    ovf_q    <= 1'b0;
                    zero_q   <= 1'b0;
                    neg_q    <= 1'b0;
                end else if (adv) begin
                    vld[k] <= v_in;
                    if (v_in) begin
                        result_q <= fin;
                        carry_q  <= csum[CHUNK];
                        ovf_q    <= ovf;
                        zero_q   <= (fin == '0);
                        neg_q    <= fin[WIDTH-1];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe: driver pushes expected results, monitor pops
// and compares whenever a result is presented.
module tb_add_sub_pipe;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned LAT   = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
        logic             zero;
        logic             neg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    add_sub_pipe_if #(.WIDTH(WIDTH)) bus ();
    add_sub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int n_in = 0;
    int n_out = 0;
    int n_flushed = 0;

    function automatic exp_t mk(logic [31:0] r, logic c, logic o, logic z, logic n);
        exp_t e;
        e.result = r; e.carry = c; e.ovf = o; e.zero = z; e.neg = n;
        return e;
    endfunction

    // Reference: plain signed/unsigned integer arithmetic, clamped when saturating.
    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic sub, logic sat);
        longint          sa, sb, r, smax, smin;
        longint unsigned ua, ub;
        exp_t            e;
        smax = (longint'(1) <<< 31) - 1;
        smin = -(longint'(1) <<< 31);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        r  = sub ? sa - sb : sa + sb;
        e.carry = sub ? (a >= b) : ((ua + ub) > 64'hFFFF_FFFF);
        e.ovf   = (r > smax) || (r < smin);
        if (sat && e.ovf) e.result = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else              e.result = r[31:0];
        e.zero = (e.result == 32'h0);
        e.neg  = e.result[31];
        return e;
    endfunction

    function automatic exp_t get_out();
        return mk(bus.result, bus.carry_out, bus.overflow, bus.zero, bus.negative);
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(7, 0))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    task automatic check_eq(input string name, input exp_t got, input exp_t e);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s got res=%h c=%b o=%b z=%b n=%b exp res=%h c=%b o=%b z=%b n=%b t=%0t",
                     name, got.result, got.carry, got.ovf, got.zero, got.neg,
                     e.result, e.carry, e.ovf, e.zero, e.neg, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int e);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, e, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic sat, input logic use_e, input exp_t e);
        exp_q.push_back(use_e ? e : model(a, b, sub, sat));
        n_in++;
    endtask

    // Offer one operand set until accepted; out_ready held at ordy meanwhile.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic sat, input logic ordy, input logic use_e, input exp_t e);
        logic took;
        took = 1'b0;
        for (int i = 0; i < 32 && !took; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sub = sub; bus.sat = sat;
            bus.out_ready = ordy;
            #1;
            took = bus.in_ready;
            if (took) push(a, b, sub, sat, use_e, e);
        end
        if (!took) check_int("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0; bus.a = $urandom(); bus.b = $urandom();
            bus.out_ready = ordy;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1, 1'b1);
        idle(2, 1'b1);
        check_int(name, exp_q.size(), 0);
    endtask

    // Monitor: compare every presented result with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output got res=%h with empty scoreboard t=%0t",
                             bus.result, $time);
                end else if (bus.out_ready) begin
                    e = exp_q.pop_front();
                    n_out++;
                    check_eq("txn", get_out(), e);
                end else begin
                    check_eq("stall_hold", get_out(), exp_q[0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx, c, n, acc;
        logic [31:0] sa [6];
        logic [31:0] sb [6];
        logic        ss [6];
        logic [31:0] ra, rb;
        logic        rv, rs, rt, ro;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.sat = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_int("rst_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_fields", get_out(), '0);
        check_int("rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner vectors with hand-derived expectations.
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1, mk(32'h8000_0000, 0, 1, 0, 1));
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1, mk(32'h7FFF_FFFF, 0, 1, 0, 0));
        send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 1'b1, mk(32'h0000_0002, 1, 0, 0, 0));
        send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b1, mk(32'hFFFF_FFFF, 0, 0, 0, 1));
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1, mk(32'h8000_0000, 1, 1, 0, 1));
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1, mk(32'h0000_0000, 1, 0, 1, 0));
        drain("directed_drain");

        // Six back-to-back operands, consumer stalls during cycles 5..7.
        for (int i = 0; i < 6; i++) begin
            sa[i] = rand_op(); sb[i] = rand_op(); ss[i] = 1'(i % 2);
        end
        idx = 0; c = 0;
        while (idx < 6 && c < 40) begin
            @(negedge clk);
            bus.out_ready = !(c >= 5 && c <= 7);
            bus.in_valid = 1'b1; bus.a = sa[idx]; bus.b = sb[idx];
            bus.sub = ss[idx]; bus.sat = 1'b1;
            #1;
            if (c >= 5 && c <= 7) begin
                check_int("stall_out_valid", int'(bus.out_valid), 1);
                check_int("stall_in_ready", int'(bus.in_ready), 0);
            end
            if (bus.in_ready) begin
                push(sa[idx], sb[idx], ss[idx], 1'b1, 1'b0, '0);
                idx++;
            end
            c++;
        end
        check_int("stall_all_accepted", idx, 6);
        drain("stall_drain");

        // Reset with three transactions in flight; operands offered during reset must vanish.
        for (int i = 0; i < 3; i++) send($urandom(), $urandom(), 1'b0, 1'b0, 1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        n_flushed += exp_q.size();
        exp_q.delete();
        #1;
        check_int("midrst_out_valid", int'(bus.out_valid), 0);
        check_eq("midrst_fields", get_out(), '0);
        repeat (2) @(negedge clk);
        check_int("midrst_in_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h0000_0010;
        bus.sub = 1'b1; bus.sat = 1'b0; bus.out_ready = 1'b1;
        #1;
        check_int("post_rst_in_ready", int'(bus.in_ready), 1);
        push(32'h1234_5678, 32'h0000_0010, 1'b1, 1'b0, 1'b1, mk(32'h1234_5668, 1, 0, 0, 0));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            n++;
        end while (bus.out_valid !== 1'b1 && n < 12);
        check_int("post_rst_latency", n, int'(LAT));
        drain("post_rst_drain");

        // Random operands, random valid and random back-pressure.
        acc = 0;
        for (int i = 0; i < 5000 && acc < 1000; i++) begin
            ra = rand_op(); rb = rand_op(); rs = 1'($urandom_range(1, 0));
            rt = 1'($urandom_range(1, 0));
            rv = ($urandom_range(99, 0) < 75);
            ro = ($urandom_range(99, 0) < 70);
            @(negedge clk);
            bus.in_valid = rv; bus.a = ra; bus.b = rb; bus.sub = rs; bus.sat = rt;
            bus.out_ready = ro;
            #1;
            if (rv && bus.in_ready) begin
                push(ra, rb, rs, rt, 1'b0, '0);
                acc++;
            end
        end
        check_int("random_accepted", acc, 1000);
        drain("random_drain");
        check_int("count_in_out", n_out, n_in - n_flushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8, bits added per pipeline stage; latency L = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set present on a, b, sub, sat.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH each  operands, two's complement or unsigned.
REQ-008 sub  input  1  0 = a+b, 1 = a-b.
REQ-009 sat  input  1  1 = signed saturation of result.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 result  output  WIDTH  sum/difference.
REQ-013 carry_out  output  1  raw carry out of MSB.
REQ-014 overflow  output  1  signed overflow of unsaturated result.
REQ-015 zero, negative  output  1 each  result==0; result[WIDTH-1], both computed after saturation.

Function
REQ-016 Arithmetic SHALL be a + (b XOR {WIDTH{sub}}) + sub; carry_out = carry of that sum (sub: 1 = no borrow).
REQ-017 overflow SHALL be 1 when a[MSB] equals the effective b[MSB] and the raw result MSB differs.
REQ-018 When sat=1 and overflow=1, result SHALL be 0x7F..F if a[MSB]=0 else 0x80..0; carry_out and overflow keep raw values.
REQ-019 When sat=0, result SHALL be the raw WIDTH-bit sum (wrap-around).
REQ-020 Stage k (0..L-1) SHALL add bits [k*CHUNK +: CHUNK] with the registered carry from stage k-1; upper operand slices and lower result slices SHALL be carried in stage registers alongside.
REQ-021 Each stage SHALL hold a valid bit; a transaction accepted at cycle t SHALL reach out_valid at cycle t+L when unstalled.
REQ-022 Pipeline advance enable adv = !out_valid | out_ready; all stages SHALL shift only when adv=1.
REQ-023 in_ready SHALL equal adv (combinational); transfer occurs when in_valid & in_ready.
REQ-024 When adv=1 and no input transfer, a bubble (valid=0) SHALL enter stage 0.
REQ-025 While out_valid=1 and out_ready=0, all output fields SHALL hold stable.
REQ-026 Throughput SHALL be one transaction per cycle with out_ready held high; order SHALL be preserved, no loss or duplication.
REQ-027 Input fields SHALL be ignored when in_valid=0 or in_ready=0.
REQ-028 L=1 (CHUNK=WIDTH) SHALL be legal and give one-cycle latency.

Reset
REQ-029 rst_n=0 SHALL immediately clear every stage valid bit; out_valid=0, result=0, carry_out=0, overflow=0, zero=0, negative=0.
REQ-030 During reset in_ready SHALL read 1 (adv true because out_valid=0); no transfer is recorded.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; first accept after deassertion appears L cycles later.

Verification (WIDTH=32, CHUNK=8, L=4)
REQ-032 a=7FFFFFFF b=00000001 sub=0 sat=0 -> after 4 cycles result=80000000 carry=0 overflow=1 negative=1; same with sat=1 -> result=7FFFFFFF overflow=1 negative=0.
REQ-033 a=00000005 b=00000003 sub=1 -> result=00000002 carry=1 overflow=0; a=0 b=1 sub=1 -> result=FFFFFFFF carry=0 overflow=0.
REQ-034 a=80000000 b=00000001 sub=1 sat=1 -> result=80000000 overflow=1; a=FFFFFFFF b=00000001 sub=0 -> result=0 carry=1 zero=1.
REQ-035 Six back-to-back inputs, out_ready=0 for cycles 5-7 -> in_ready=0 during stall, outputs held, all six results delivered in order, none lost.
REQ-036 Assert rst_n=0 with 3 transactions in flight -> out_valid=0 same cycle, no stale result emerges after release; new input returns after exactly 4 cycles.
REQ-037 Random 1000 vectors with random out_ready vs. behavioural model -> all fields match, count in = count out.
